// File: rtl/hex_pkg.sv
// Shared seven-segment constants for the hex display blocks.
// All glyphs are active-low: bit0 = segment a ... bit6 = segment g.
package hex_pkg;

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Standard 0-F glyph table, indexed by nibble value (entry 15 is listed first).
    localparam logic [15:0][6:0] SEG_GLYPHS = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/hex_decoder.sv
// Combinational single-digit hex to seven-segment decoder, active-low output.
module hex_decoder
    import hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for this nibble.
    always_comb begin
        seg = SEG_GLYPHS[nibble];
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Registered multi-digit hex display controller: static per-digit outputs
// plus a time-multiplexed scan output, with leading-zero suppression,
// per-digit blink and a global blank.
module hex_display_ctrl
    import hex_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int BLINK_DIV = 25_000_000,
    parameter int SCAN_DIV  = 50_000
)
(
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lzs_en,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [6:0]            seg_mux,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0]     value_q;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_ph;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           scan_idx;
    logic [DIGITS-1:0][6:0]  raw_glyph;
    logic [DIGITS-1:0][6:0]  final_glyph;
    logic [DIGITS-1:0]       suppress;
    logic                    seen_nonzero;

    // One decoder per digit, fed from the captured value.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dec
            hex_decoder u_dec (
                .nibble (value_q[4*gi +: 4]),
                .seg    (raw_glyph[gi])
            );
        end
    endgenerate

    // Scan from the top digit down; a digit is suppressed until the first nonzero nibble.
    always_comb begin
        suppress     = '0;
        seen_nonzero = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (value_q[4*i +: 4] != 4'h0) begin
                seen_nonzero = 1'b1;
            end
            suppress[i] = lzs_en && !seen_nonzero;
        end
    end

    // Apply blank, then suppression, then blink on top of the decoded glyphs.
    always_comb begin
        final_glyph = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (blank) begin
                final_glyph[i] = SEG_BLANK;
            end else if (suppress[i]) begin
                final_glyph[i] = SEG_BLANK;
            end else if (blink_ph && blink_mask[i]) begin
                final_glyph[i] = SEG_BLANK;
            end else begin
                final_glyph[i] = raw_glyph[i];
            end
        end
    end

    // Capture the displayed value on load.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= value;
        end
    end

    // Blink timebase; a load restarts it so fresh data is shown lit for a full half-period.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (load) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Scan timebase; free-running and unaffected by load.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Output registers; segments and digit select come from the same index so they switch together.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            HEX     <= '1;
            seg_mux <= SEG_BLANK;
            dig_sel <= '1;
        end else begin
            HEX     <= final_glyph;
            seg_mux <= final_glyph[scan_idx];
            dig_sel <= ~(DIGITS'(1) << scan_idx);
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl with a small behavioural model.
module tb_hex_display_ctrl;

    localparam int DIGITS    = 6;
    localparam int BLINK_DIV = 4;
    localparam int SCAN_DIV  = 3;

    logic        clock = 1'b0;
    logic        Resetn;
    logic        load;
    logic [23:0] value;
    logic        lzs_en;
    logic [5:0]  blinkMask;
    logic        blank;
    logic [41:0] hexOut;
    logic [6:0]  segMux;
    logic [5:0]  digSel;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [23:0] mValue;
    int          mBlinkCnt;
    bit          mBlinkPh;
    int          mScanCnt;
    int          mScanIdx;
    logic [41:0] expHex;
    logic [6:0]  expSeg;
    logic [5:0]  expSel;

    int glyphTab [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                          'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};

    hex_display_ctrl #(
        .DIGITS    (DIGITS),
        .BLINK_DIV (BLINK_DIV),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .Clock      (clock),
        .Resetn     (Resetn),
        .load       (load),
        .value      (value),
        .lzs_en     (lzs_en),
        .blink_mask (blinkMask),
        .blank      (blank),
        .HEX        (hexOut),
        .seg_mux    (segMux),
        .dig_sel    (digSel)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Count a comparison and report any difference
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Displayed glyph of digit i given the model's current value and the sampled controls
    function automatic logic [6:0] digitGlyph(int i, bit lz, logic [5:0] mask, bit bl);
        int top = 0;
        int nib;
        for (int d = 0; d < DIGITS; d++) begin
            if (((mValue >> (4 * d)) & 24'hF) != 24'h0) top = d;
        end
        nib = int'((mValue >> (4 * i)) & 24'hF);
        if (bl) return 7'h7F;
        if (lz && i > top) return 7'h7F;
        if (mBlinkPh && mask[i]) return 7'h7F;
        return 7'(glyphTab[nib]);
    endfunction

    task automatic modelReset();
        mValue    = '0;
        mBlinkCnt = 0;
        mBlinkPh  = 1'b0;
        mScanCnt  = 0;
        mScanIdx  = 0;
    endtask

    // Drive inputs for one clock, advance the model and compare all outputs
    task automatic applyStimulus(input bit ld, input logic [23:0] v, input bit lz,
                                 input logic [5:0] mask, input bit bl);
        load      = ld;
        value     = v;
        lzs_en    = lz;
        blinkMask = mask;
        blank     = bl;
        @(posedge clock);
        for (int i = 0; i < DIGITS; i++) expHex[7*i +: 7] = digitGlyph(i, lz, mask, bl);
        expSeg = expHex[7*mScanIdx +: 7];
        expSel = ~(6'b1 << mScanIdx);
        if (ld) begin
            mValue    = v;
            mBlinkCnt = 0;
            mBlinkPh  = 1'b0;
        end else if (mBlinkCnt == BLINK_DIV - 1) begin
            mBlinkCnt = 0;
            mBlinkPh  = ~mBlinkPh;
        end else begin
            mBlinkCnt++;
        end
        if (mScanCnt == SCAN_DIV - 1) begin
            mScanCnt = 0;
            mScanIdx = (mScanIdx + 1) % DIGITS;
        end else begin
            mScanCnt++;
        end
        #1;
        checkOutput("hex", hexOut, expHex);
        checkOutput("seg_mux", segMux, expSeg);
        checkOutput("dig_sel", digSel, expSel);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_hex"}, hexOut, {42{1'b1}});
        checkOutput({tag, "_seg"}, segMux, 7'h7F);
        checkOutput({tag, "_sel"}, digSel, 6'h3F);
    endtask

    // Assert reset between edges and check that outputs clear without a clock edge
    task automatic asyncReset();
        @(negedge clock);
        #2;
        Resetn = 1'b0;
        #1;
        checkResetOutputs("async_rst");
        modelReset();
        #1;
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn    = 1'b1;
        load      = 1'b0;
        value     = '0;
        lzs_en    = 1'b0;
        blinkMask = '0;
        blank     = 1'b0;
        #2;
        Resetn = 1'b0;
        load   = 1'b1;
        value  = 24'h123456;
        modelReset();

        // Reset held with load asserted
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            checkResetOutputs("rst_hold");
        end
        @(negedge clock);
        Resetn = 1'b1;

        // First edge after reset shows zeros everywhere
        applyStimulus(1'b0, 24'h0, 1'b0, 6'h0, 1'b0);
        checkOutput("first_zero", hexOut, {6{7'h40}});

        // Load latency with suppression
        applyStimulus(1'b1, 24'h00A3F0, 1'b1, 6'h0, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b1, 6'h0, 1'b0);
        checkOutput("load_a3f0", hexOut, {7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h40});

        // Zero value with suppression, then blank
        applyStimulus(1'b1, 24'h0, 1'b1, 6'h0, 1'b0);
        applyStimulus(1'b0, 24'h0, 1'b1, 6'h0, 1'b0);
        checkOutput("lzs_zero", hexOut, {{5{7'h7F}}, 7'h40});
        applyStimulus(1'b0, 24'h0, 1'b1, 6'h0, 1'b1);
        checkOutput("blank_all", hexOut, {6{7'h7F}});

        // Blink on digit 0 with a load in the middle of a dark phase
        applyStimulus(1'b1, 24'h000005, 1'b0, 6'b000001, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            applyStimulus(k == 7, 24'h000007, 1'b0, 6'b000001, 1'b0);
        end

        // Randomized traffic with an async reset dropped in
        for (int k = 0; k < 400; k++) begin
            if (k == 150 || k == 301) asyncReset();
            applyStimulus($urandom_range(7) == 0,
                          24'($urandom),
                          1'($urandom),
                          6'($urandom),
                          $urandom_range(9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
